fir_axil_cfg: RTL and testbench
===============================

# fir_axil_cfg

AXI4-Lite slave front end for the FIR accelerator, sitting directly upstream of the 11-entry tap-coefficient RAM. It decodes host register accesses and drives the RAM write port and read port. For reads it absorbs the RAM's one-cycle registered read latency. It also holds the control/status and data-length registers handed to the FIR engine.

## Interface
Parameters:
- ADDR_WIDTH, 12, AXI-Lite and tap-RAM address width
- DATA_WIDTH, 32, data width
- TAP_NUM, 11, number of tap words

Ports:
- axis_clk  in  1  sole clock
- axis_rst_n  in  1  asynchronous, active-low reset
- awvalid / awready  in / out  1  write-address handshake
- awaddr  in  ADDR_WIDTH  write byte address
- wvalid / wready  in / out  1  write-data handshake
- wdata  in  DATA_WIDTH  write data
- bvalid / bready  out / in  1  write-response handshake
- bresp  out  2  write response
- arvalid / arready  in / out  1  read-address handshake
- araddr  in  ADDR_WIDTH  read byte address
- rvalid / rready  out / in  1  read-data handshake
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- tap_we, tap_re  out  1  tap-RAM write and read enables
- tap_waddr, tap_raddr  out  ADDR_WIDTH  tap word index, 0..TAP_NUM-1
- tap_wdi  out  DATA_WIDTH  tap write data
- tap_rdo  in  DATA_WIDTH  tap-RAM read data, valid one cycle after tap_re
- ap_idle  in  1  engine idle level
- ap_done_p  in  1  engine done pulse
- ap_start  out  1  one-cycle start pulse
- data_length  out  DATA_WIDTH  sample count register

## Operation
- Address map:
  - 0x00 control/status. Write: bit0 = start. Read: {29'b0, ap_idle, done_sticky, 1'b0}.
  - 0x10 data_length, read/write.
  - 0x20 + 4*i for i = 0..TAP_NUM-1: tap i, word index = (addr-0x20)>>2.
  - Any other address is unmapped.
- Write channel:
  - AW and W are each accepted independently into a one-entry holding register; aw/wready is high while that register is empty.
  - When both holding registers are full, the write executes in one cycle: tap_we pulse, or register update.
  - bvalid then rises in the next cycle and is held until bready; both holding registers free on the B handshake.
- Read channel, states R_IDLE → R_RAM → R_RESP → R_IDLE:
  - arready is high only in R_IDLE.
  - R_RAM: tap_re=1 and tap_raddr=index, for tap addresses only.
  - R_RESP: rvalid=1. rdata = tap_rdo for taps (held, because tap_re is now low), otherwise the register value, 0 when unmapped. Held until rready.
- Engine busy (ap_idle=0):
  - Tap writes are dropped with no tap_we and an OKAY response.
  - Tap reads issue no tap_re and return 32'hFFFF_FFFF.
  - Writes of start are ignored.
- Start: a write of bit0=1 to 0x00 while ap_idle=1 pulses ap_start for exactly one cycle and clears done_sticky.
- done_sticky:
  - Set by ap_done_p.
  - Cleared when the R_RESP handshake of a 0x00 read completes.
  - If set and clear happen in the same cycle, set wins.
- Read and write channels are fully independent; a tap write and a tap read to the same index in the same cycle return the old value.

## Timing
- Reset: awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=0; rdata=0; tap_we=tap_re=0; tap_waddr=tap_raddr=0; tap_wdi=0; ap_start=0; data_length=0; done_sticky=0; read FSM in R_IDLE.
- Reset asserted mid-transaction: pending holding registers and any in-flight read are discarded.
- Write latency:
  - With AW and W handshaken in cycle N, tap_we is high in N+1 and bvalid in N+2.
  - If AW and W handshakes land in different cycles, latency is counted from the later one.
- Read latency: AR handshake in cycle N → tap_re in N+1 → rvalid in N+2, for every address class.
- Back-to-back: with bready or rready held high, a new transaction can be accepted in the cycle after the response handshake.
- All outputs are registered; no combinational path from AXI inputs to AXI outputs.

## Configuration
- FIR_AXIL_SLVERR_EN defined: accesses to unmapped addresses return SLVERR (2'b10) on bresp/rresp. Tap accesses while busy also return SLVERR, with rdata=0.
- Not defined: every response is OKAY (2'b00) and busy tap reads return 32'hFFFF_FFFF.

## Test plan
- Tap write/read, ap_idle=1: write 0x20+4*k = k*3+1 for k=0..10, then read all 11 → each matches, tap_waddr=k, rvalid exactly 2 cycles after AR.
- Split AW/W: AW at cycle 0, W at cycle 5 to 0x10 = 64 → single tap-free write, bvalid at cycle 7, data_length=64.
- Backpressure: bready and rready low for 10 cycles → bvalid/rvalid and rdata remain stable, awready/arready stay low until the handshake.
- Start/done: write 0x00=1 → one ap_start pulse. ap_done_p → read 0x00 gives 0x6 (with ap_idle=1); a second read gives 0x4.
- Busy: ap_idle=0, write tap 3=0xAA → no tap_we; a read of tap 3 gives 32'hFFFF_FFFF. After idle returns, tap 3 holds its old value.
- Unmapped 0x100 write and read, plus asynchronous reset mid-read → OKAY/0 without FIR_AXIL_SLVERR_EN and SLVERR with it; after reset, outputs return to their reset values and no rvalid appears.

Source files
------------

// File: rtl/fir_axil_cfg.sv
// AXI4-Lite register/tap-RAM front end for the FIR engine.
// Optional build macro: FIR_AXIL_SLVERR_EN (SLVERR on unmapped and busy tap accesses).
module fir_axil_cfg #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAP_NUM    = 11
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  tap_we,
  output logic                  tap_re,
  output logic [ADDR_WIDTH-1:0] tap_waddr,
  output logic [ADDR_WIDTH-1:0] tap_raddr,
  output logic [DATA_WIDTH-1:0] tap_wdi,
  input  logic [DATA_WIDTH-1:0] tap_rdo,
  input  logic                  ap_idle,
  input  logic                  ap_done_p,
  output logic                  ap_start,
  output logic [DATA_WIDTH-1:0] data_length
);

`ifdef FIR_AXIL_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_ERR    = SLVERR_EN ? RESP_SLVERR : RESP_OKAY;
  localparam logic [DATA_WIDTH-1:0] BUSY_RDATA = SLVERR_EN ? '0 : '1;

  typedef enum logic [1:0] {R_IDLE, R_RAM, R_RESP} rstate_t;
  typedef enum logic [1:0] {K_CTRL, K_LEN, K_TAP, K_NONE} akind_t;

  function automatic akind_t decode(input logic [ADDR_WIDTH-1:0] a);
    if (a == '0) return K_CTRL;
    if (a == ADDR_WIDTH'(16)) return K_LEN;
    if (a >= ADDR_WIDTH'(32) && a < ADDR_WIDTH'(32 + 4 * TAP_NUM)) return K_TAP;
    return K_NONE;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] tap_idx(input logic [ADDR_WIDTH-1:0] a);
    return (a - ADDR_WIDTH'(32)) >> 2;
  endfunction

  // ---------------- write channel ----------------
  logic                  r_aw_full, r_w_full, r_wr_issued, r_bvalid;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_tap_waddr;
  logic [DATA_WIDTH-1:0] r_wdata, r_tap_wdi, r_data_length;
  logic [1:0]            r_bresp;
  logic                  r_tap_we, r_ap_start, r_done_sticky;
  logic                  w_aw_hs, w_w_hs, w_wr_go, w_start;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdat;
  akind_t                w_wkind;

  // A write may issue on the same edge its last handshake lands, so tap_we follows it by one cycle.
  assign w_aw_hs = awvalid & ~r_aw_full;
  assign w_w_hs  = wvalid & ~r_w_full;
  assign w_waddr = r_aw_full ? r_awaddr : awaddr;
  assign w_wdat  = r_w_full ? r_wdata : wdata;
  assign w_wr_go = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs) & ~r_wr_issued;
  assign w_wkind = decode(w_waddr);
  assign w_start = w_wr_go & (w_wkind == K_CTRL) & w_wdat[0] & ap_idle;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_aw_full     <= 1'b0;
      r_w_full      <= 1'b0;
      r_wr_issued   <= 1'b0;
      r_bvalid      <= 1'b0;
      r_awaddr      <= '0;
      r_wdata       <= '0;
      r_bresp       <= RESP_OKAY;
      r_tap_we      <= 1'b0;
      r_tap_waddr   <= '0;
      r_tap_wdi     <= '0;
      r_ap_start    <= 1'b0;
      r_data_length <= '0;
    end else begin
      r_tap_we   <= 1'b0;
      r_ap_start <= 1'b0;
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_awaddr  <= awaddr;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_wdata  <= wdata;
      end
      if (w_wr_go) begin
        r_wr_issued <= 1'b1;
        r_bresp     <= RESP_OKAY;
        case (w_wkind)
          K_CTRL: r_ap_start <= w_start;
          K_LEN:  r_data_length <= w_wdat;
          K_TAP:
            if (ap_idle) begin
              r_tap_we    <= 1'b1;
              r_tap_waddr <= tap_idx(w_waddr);
              r_tap_wdi   <= w_wdat;
            end else begin
              r_bresp <= RESP_ERR;
            end
          default: r_bresp <= RESP_ERR;
        endcase
      end
      if (r_wr_issued && !r_bvalid) r_bvalid <= 1'b1;
      if (r_bvalid && bready) begin
        r_bvalid    <= 1'b0;
        r_wr_issued <= 1'b0;
        r_aw_full   <= 1'b0;
        r_w_full    <= 1'b0;
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t               r_rstate, w_rnext;
  akind_t                r_rkind;
  logic                  r_rbusy, r_tap_re, r_rfresh;
  logic [ADDR_WIDTH-1:0] r_tap_raddr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  w_rd_clr;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) r_rstate <= R_IDLE;
    else             r_rstate <= w_rnext;
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (arvalid) w_rnext = R_RAM;
      R_RAM:   w_rnext = R_RESP;
      R_RESP:  if (rready) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  assign w_rd_clr = (r_rstate == R_RESP) & rready & (r_rkind == K_CTRL);

  // tap_rdo is only valid in the first R_RESP cycle; r_rfresh forwards it and then latches it.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_rkind     <= K_NONE;
      r_rbusy     <= 1'b0;
      r_tap_re    <= 1'b0;
      r_tap_raddr <= '0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
      r_rfresh    <= 1'b0;
    end else begin
      r_tap_re <= 1'b0;
      r_rfresh <= 1'b0;
      case (r_rstate)
        R_IDLE:
          if (arvalid) begin
            r_rkind <= decode(araddr);
            r_rbusy <= ~ap_idle;
            if (decode(araddr) == K_TAP && ap_idle) begin
              r_tap_re    <= 1'b1;
              r_tap_raddr <= tap_idx(araddr);
            end
          end
        R_RAM: begin
          r_rresp <= RESP_OKAY;
          case (r_rkind)
            K_CTRL: r_rdata <= DATA_WIDTH'({ap_idle, r_done_sticky, 1'b0});
            K_LEN:  r_rdata <= r_data_length;
            K_TAP:
              if (r_rbusy) begin
                r_rdata <= BUSY_RDATA;
                r_rresp <= RESP_ERR;
              end else begin
                r_rfresh <= 1'b1;
              end
            default: begin
              r_rdata <= '0;
              r_rresp <= RESP_ERR;
            end
          endcase
        end
        R_RESP: if (r_rfresh) r_rdata <= tap_rdo;
        default: ;
      endcase
    end
  end

  // Set wins over either clear source.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n)             r_done_sticky <= 1'b0;
    else if (ap_done_p)          r_done_sticky <= 1'b1;
    else if (w_rd_clr || w_start) r_done_sticky <= 1'b0;
  end

  assign awready     = ~r_aw_full;
  assign wready      = ~r_w_full;
  assign bvalid      = r_bvalid;
  assign bresp       = r_bresp;
  assign arready     = (r_rstate == R_IDLE);
  assign rvalid      = (r_rstate == R_RESP);
  assign rdata       = r_rfresh ? tap_rdo : r_rdata;
  assign rresp       = r_rresp;
  assign tap_we      = r_tap_we;
  assign tap_re      = r_tap_re;
  assign tap_waddr   = r_tap_waddr;
  assign tap_raddr   = r_tap_raddr;
  assign tap_wdi     = r_tap_wdi;
  assign ap_start    = r_ap_start;
  assign data_length = r_data_length;

endmodule

// File: tb/tb_fir_axil_cfg.sv
// Directed bench for fir_axil_cfg with a behavioural tap RAM and response scoreboards.
module tb_fir_axil_cfg;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TN = 11;

`ifdef FIR_AXIL_SLVERR_EN
  localparam logic [1:0]    ERR     = 2'b10;
  localparam logic [DW-1:0] BUSY_RD = 32'h0;
`else
  localparam logic [1:0]    ERR     = 2'b00;
  localparam logic [DW-1:0] BUSY_RD = 32'hFFFF_FFFF;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata, tap_wdi, data_length;
  logic [DW-1:0] tap_rdo = '0;
  logic          tap_we, tap_re, ap_start;
  logic [AW-1:0] tap_waddr, tap_raddr;
  logic          ap_idle = 1'b1, ap_done_p = 1'b0;

  logic [DW-1:0] mem [16];

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rsp_t;
  rsp_t rq[$];
  logic [1:0] wq[$];

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  fir_axil_cfg #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAP_NUM(TN)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .tap_we(tap_we), .tap_re(tap_re), .tap_waddr(tap_waddr), .tap_raddr(tap_raddr),
    .tap_wdi(tap_wdi), .tap_rdo(tap_rdo),
    .ap_idle(ap_idle), .ap_done_p(ap_done_p), .ap_start(ap_start), .data_length(data_length)
  );

  // Registered-read tap RAM; a same-cycle write and read return the old word.
  always @(posedge clk) begin
    if (tap_we) mem[tap_waddr[3:0]] <= tap_wdi;
    if (tap_re) tap_rdo <= mem[tap_raddr[3:0]];
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic exp_we,
                           input logic exp_start, input logic [1:0] exp_resp, input bit bp);
    int t;
    logic [1:0] e;
    wq.push_back(exp_resp);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = !bp;
    t = 0;
    while (!(awready && wready) && t < 50) begin @(posedge clk); #1; t++; end
    chk("wr_ready_wait", 32'(t < 50), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("tap_we", 32'(tap_we), 32'(exp_we));
    if (exp_we) begin
      chk("tap_waddr", 32'(tap_waddr), 32'((a - 12'h20) >> 2));
      chk("tap_wdi", tap_wdi, d);
    end
    chk("ap_start", 32'(ap_start), 32'(exp_start));
    chk("bvalid_early", 32'(bvalid), 32'd0);
    @(posedge clk); #1;
    e = wq.pop_front();
    chk("bvalid_lat", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), 32'(e));
    chk("tap_we_pulse", 32'(tap_we), 32'd0);
    chk("ap_start_pulse", 32'(ap_start), 32'd0);
    if (bp) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        chk("bp_bvalid", 32'(bvalid), 32'd1);
        chk("bp_bresp", 32'(bresp), 32'(e));
        chk("bp_awready", 32'(awready), 32'd0);
      end
      bready = 1'b1;
    end
    @(posedge clk); #1;
    chk("bvalid_clr", 32'(bvalid), 32'd0);
    chk("awready_free", 32'(awready), 32'd1);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d, input logic [1:0] exp_resp,
                          input logic exp_re, input bit bp);
    int t;
    rsp_t e;
    rq.push_back({exp_d, exp_resp});
    araddr = a; arvalid = 1'b1; rready = !bp;
    t = 0;
    while (!arready && t < 50) begin @(posedge clk); #1; t++; end
    chk("ar_ready_wait", 32'(t < 50), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("tap_re", 32'(tap_re), 32'(exp_re));
    if (exp_re) chk("tap_raddr", 32'(tap_raddr), 32'((a - 12'h20) >> 2));
    chk("rvalid_early", 32'(rvalid), 32'd0);
    chk("arready_busy", 32'(arready), 32'd0);
    @(posedge clk); #1;
    e = rq.pop_front();
    chk("rvalid_lat", 32'(rvalid), 32'd1);
    chk("tap_re_pulse", 32'(tap_re), 32'd0);
    chk("rdata", rdata, e.data);
    chk("rresp", 32'(rresp), 32'(e.resp));
    if (bp) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        chk("bp_rvalid", 32'(rvalid), 32'd1);
        chk("bp_rdata", rdata, e.data);
        chk("bp_arready", 32'(arready), 32'd0);
      end
      rready = 1'b1;
    end
    @(posedge clk); #1;
    chk("rvalid_clr", 32'(rvalid), 32'd0);
    chk("arready_free", 32'(arready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, 32'(awready), 32'd1);
    chk({tag, "_wready"}, 32'(wready), 32'd1);
    chk({tag, "_arready"}, 32'(arready), 32'd1);
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_resp"}, 32'({bresp, rresp}), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_tap_en"}, 32'({tap_we, tap_re}), 32'd0);
    chk({tag, "_tap_addr"}, 32'({tap_waddr, tap_raddr}), 32'd0);
    chk({tag, "_tap_wdi"}, tap_wdi, 32'd0);
    chk({tag, "_ap_start"}, 32'(ap_start), 32'd0);
    chk({tag, "_data_length"}, data_length, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tap write then read-back with the engine idle.
    for (int k = 0; k < TN; k++)
      axi_write(12'(32 + 4 * k), 32'(k * 3 + 1), 1'b1, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < TN; k++)
      axi_read(12'(32 + 4 * k), 32'(k * 3 + 1), 2'b00, 1'b1, 1'b0);

    // Split AW/W to data_length.
    awaddr = 12'h010; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      chk("split_awready", 32'(awready), 32'd0);
      chk("split_wready", 32'(wready), 32'd1);
      chk("split_bvalid", 32'(bvalid), 32'd0);
      @(posedge clk); #1;
    end
    wdata = 32'd64; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    chk("split_tap_we", 32'(tap_we), 32'd0);
    chk("split_data_length", data_length, 32'd64);
    chk("split_bvalid_n1", 32'(bvalid), 32'd0);
    @(posedge clk); #1;
    chk("split_bvalid_n2", 32'(bvalid), 32'd1);
    chk("split_bresp", 32'(bresp), 32'd0);
    @(posedge clk); #1;
    chk("split_bvalid_clr", 32'(bvalid), 32'd0);
    axi_read(12'h010, 32'd64, 2'b00, 1'b0, 1'b0);

    // Backpressure on both response channels.
    axi_write(12'h010, 32'h55, 1'b0, 1'b0, 2'b00, 1'b1);
    chk("bp_data_length", data_length, 32'h55);
    axi_read(12'h034, 32'd16, 2'b00, 1'b1, 1'b1);

    // Start pulse and done_sticky.
    axi_write(12'h000, 32'h1, 1'b0, 1'b1, 2'b00, 1'b0);
    ap_done_p = 1'b1;
    @(posedge clk); #1;
    ap_done_p = 1'b0;
    axi_read(12'h000, 32'h6, 2'b00, 1'b0, 1'b0);
    axi_read(12'h000, 32'h4, 2'b00, 1'b0, 1'b0);

    // Engine busy: tap access blocked, start ignored.
    ap_idle = 1'b0;
    axi_write(12'h02C, 32'hAA, 1'b0, 1'b0, ERR, 1'b0);
    axi_read(12'h02C, BUSY_RD, ERR, 1'b0, 1'b0);
    axi_write(12'h000, 32'h1, 1'b0, 1'b0, 2'b00, 1'b0);
    axi_read(12'h000, 32'h0, 2'b00, 1'b0, 1'b0);
    ap_idle = 1'b1;
    axi_read(12'h02C, 32'd10, 2'b00, 1'b1, 1'b0);

    // Unmapped address.
    axi_write(12'h100, 32'h1234, 1'b0, 1'b0, ERR, 1'b0);
    axi_read(12'h100, 32'h0, ERR, 1'b0, 1'b0);

    // Asynchronous reset while a tap read is in flight.
    araddr = 12'h028; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("abort_tap_re", 32'(tap_re), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_rvalid", 32'(rvalid), 32'd0);
    end
    axi_read(12'h028, 32'd7, 2'b00, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
